// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit PHT counter encodings, the default
// PHT index width and the {index, pred} record passed from fetch to retire.
package bp_pkg;

  localparam int BP_LOG_INDEX = 10;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_e;

  typedef struct packed {
    logic [BP_LOG_INDEX-1:0] index;
    logic                    pred;
  } bp_entry_t;

  // Predicted direction of a 2-bit saturating counter is its MSB.
  function automatic logic bp_ctr_pred(input bp_ctr_e ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/bp_fifo.sv
// Circular buffer with push, pop, flush and an occupancy count. The head
// entry is held in a register so the consumer sees it with no array read
// in its path; a push into the slot becoming head is bypassed into it.
module bp_fifo #(
  parameter int DEPTH     = 8,
  parameter int LOG_DEPTH = 3,
  parameter int WIDTH     = 11
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 i_push,
  input  logic [WIDTH-1:0]     i_push_data,
  input  logic                 i_pop,
  input  logic                 i_flush,
  output logic [WIDTH-1:0]     o_head_data,
  output logic [LOG_DEPTH:0]   o_count
);

  localparam logic [LOG_DEPTH-1:0] PTR_ONE  = 1;
  localparam logic [LOG_DEPTH:0]   CNT_ONE  = 1;
  localparam logic [LOG_DEPTH:0]   CNT_FULL = DEPTH[LOG_DEPTH:0];

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [LOG_DEPTH-1:0] r_head;
  logic [LOG_DEPTH-1:0] r_tail;
  logic [LOG_DEPTH:0]   r_count;
  logic [WIDTH-1:0]     r_head_data;

  logic                 w_wr_en;
  logic                 w_rd_en;
  logic [LOG_DEPTH-1:0] w_head_nxt;
  logic [LOG_DEPTH-1:0] w_tail_nxt;
  logic [LOG_DEPTH:0]   w_count_nxt;
  logic [WIDTH-1:0]     w_head_data_nxt;

  // Pushes are refused when full or flushing; pops only when not empty.
  assign w_wr_en = i_push & ~i_flush & (r_count != CNT_FULL);
  assign w_rd_en = i_pop & (r_count != '0);

  // Next pointer, count and head-entry values.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (i_flush) begin
      w_head_nxt  = '0;
      w_tail_nxt  = '0;
      w_count_nxt = '0;
    end else begin
      if (w_wr_en) w_tail_nxt = r_tail + PTR_ONE;
      if (w_rd_en) w_head_nxt = r_head + PTR_ONE;
      case ({w_wr_en, w_rd_en})
        2'b10:   w_count_nxt = r_count + CNT_ONE;
        2'b01:   w_count_nxt = r_count - CNT_ONE;
        default: w_count_nxt = r_count;
      endcase
    end
    // The new head slot equals the old tail only when the queue is (becoming)
    // empty, so the entry being pushed there is the next head.
    if (w_wr_en && (r_tail == w_head_nxt)) w_head_data_nxt = i_push_data;
    else                                   w_head_data_nxt = r_mem[w_head_nxt];
  end

  // Entry storage written at the tail.
  // NOTE: the array is deliberately not reset; count decides validity, so stale slots are never consumed.
  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[r_tail] <= i_push_data;
  end

  // Pointer, count and head-entry registers.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_head_data <= '0;
    end else begin
      r_head      <= w_head_nxt;
      r_tail      <= w_tail_nxt;
      r_count     <= w_count_nxt;
      r_head_data <= w_head_data_nxt;
    end
  end

  assign o_head_data = r_head_data;
  assign o_count     = r_count;

endmodule

// File: rtl/bp_update_queue.sv
// Retire-side PHT update generator. Records {index, pred} for each fetched
// branch, pops them in order at retire and drives one registered PHT write
// per retired branch together with a mispredict pulse. Retiring with an
// empty queue sets a sticky underflow flag.
// Optional build macro BPUQ_STATS_EN adds 32-bit retired/mispredict counters.
// LOG_INDEX must equal bp_pkg::BP_LOG_INDEX, the width of the shared entry type.
module bp_update_queue
  import bp_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int LOG_DEPTH = 3,
  parameter int LOG_INDEX = BP_LOG_INDEX
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 alloc_valid_i,
  input  logic [LOG_INDEX-1:0] alloc_index_i,
  input  logic                 alloc_pred_i,
  output logic                 alloc_ready_o,
  input  logic                 ret_valid_i,
  input  logic                 ret_brdir_i,
  input  logic                 flush_i,
  output logic [LOG_INDEX-1:0] pht_wt_index_o,
  output logic                 pht_brdir_we_o,
  output logic                 pht_brdir_o,
  output logic                 mispredict_o,
  output logic                 underflow_o,
  output logic [LOG_DEPTH:0]   count_o
`ifdef BPUQ_STATS_EN
  ,
  output logic [31:0]          stat_retired_o,
  output logic [31:0]          stat_mispred_o
`endif
);

  localparam logic [LOG_DEPTH:0] CNT_FULL = DEPTH[LOG_DEPTH:0];

  bp_entry_t            w_alloc_entry;
  bp_entry_t            w_head_entry;
  logic [LOG_DEPTH:0]   w_count;
  logic                 w_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_underflow_evt;
  logic                 w_mispredict;

  logic [LOG_INDEX-1:0] r_pht_index;
  logic                 r_pht_we;
  logic                 r_pht_brdir;
  logic                 r_mispredict;
  logic                 r_underflow;

  assign w_alloc_entry   = {alloc_index_i, alloc_pred_i};
  // No bypass when full, even if a retire frees a slot this cycle.
  assign w_ready         = (w_count != CNT_FULL);
  // An allocation in the flush cycle belongs to the discarded path.
  assign w_push          = alloc_valid_i & w_ready & ~flush_i;
  // A retire in the flush cycle is still a committed branch and is popped.
  assign w_pop           = ret_valid_i & (w_count != '0);
  assign w_underflow_evt = ret_valid_i & (w_count == '0);
  assign w_mispredict    = w_head_entry.pred ^ ret_brdir_i;

  bp_fifo #(
    .DEPTH     (DEPTH),
    .LOG_DEPTH (LOG_DEPTH),
    .WIDTH     ($bits(bp_entry_t))
  ) u_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_push_data (w_alloc_entry),
    .i_pop       (w_pop),
    .i_flush     (flush_i),
    .o_head_data (w_head_entry),
    .o_count     (w_count)
  );

  // PHT update register, mispredict pulse and sticky underflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pht_index  <= '0;
      r_pht_we     <= 1'b0;
      r_pht_brdir  <= 1'b0;
      r_mispredict <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_pht_we     <= w_pop;
      r_mispredict <= w_pop & w_mispredict;
      if (w_pop) begin
        r_pht_index <= w_head_entry.index;
        r_pht_brdir <= ret_brdir_i;
      end
      if (w_underflow_evt) r_underflow <= 1'b1;
    end
  end

`ifdef BPUQ_STATS_EN
  logic [31:0] r_stat_retired;
  logic [31:0] r_stat_mispred;

  // Free-running retire and mispredict counters; flush does not touch them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_retired <= '0;
      r_stat_mispred <= '0;
    end else begin
      if (w_pop)                r_stat_retired <= r_stat_retired + 32'd1;
      if (w_pop & w_mispredict) r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign stat_retired_o = r_stat_retired;
  assign stat_mispred_o = r_stat_mispred;
`endif

  assign alloc_ready_o  = w_ready;
  assign count_o        = w_count;
  assign pht_wt_index_o = r_pht_index;
  assign pht_brdir_we_o = r_pht_we;
  assign pht_brdir_o    = r_pht_brdir;
  assign mispredict_o   = r_mispredict;
  assign underflow_o    = r_underflow;

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed bench for bp_update_queue: reset values, mispredict update,
// fill/drain order, full-queue alloc drop, pointer wrap, flush, underflow,
// asynchronous reset mid-update and (with BPUQ_STATS_EN) the counters.
module tb_bp_update_queue;

  localparam int DEPTH     = 8;
  localparam int LOG_DEPTH = 3;
  localparam int LOG_INDEX = 10;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 alloc_valid_i;
  logic [LOG_INDEX-1:0] alloc_index_i;
  logic                 alloc_pred_i;
  logic                 alloc_ready_o;
  logic                 ret_valid_i;
  logic                 ret_brdir_i;
  logic                 flush_i;
  logic [LOG_INDEX-1:0] pht_wt_index_o;
  logic                 pht_brdir_we_o;
  logic                 pht_brdir_o;
  logic                 mispredict_o;
  logic                 underflow_o;
  logic [LOG_DEPTH:0]   count_o;
`ifdef BPUQ_STATS_EN
  logic [31:0]          stat_retired_o;
  logic [31:0]          stat_mispred_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  bp_update_queue #(
    .DEPTH     (DEPTH),
    .LOG_DEPTH (LOG_DEPTH),
    .LOG_INDEX (LOG_INDEX)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .alloc_valid_i  (alloc_valid_i),
    .alloc_index_i  (alloc_index_i),
    .alloc_pred_i   (alloc_pred_i),
    .alloc_ready_o  (alloc_ready_o),
    .ret_valid_i    (ret_valid_i),
    .ret_brdir_i    (ret_brdir_i),
    .flush_i        (flush_i),
    .pht_wt_index_o (pht_wt_index_o),
    .pht_brdir_we_o (pht_brdir_we_o),
    .pht_brdir_o    (pht_brdir_o),
    .mispredict_o   (mispredict_o),
    .underflow_o    (underflow_o),
    .count_o        (count_o)
`ifdef BPUQ_STATS_EN
    ,
    .stat_retired_o (stat_retired_o),
    .stat_mispred_o (stat_mispred_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic av, input logic [LOG_INDEX-1:0] idx, input logic pred,
                       input logic rv, input logic dir, input logic fl);
    alloc_valid_i = av;
    alloc_index_i = idx;
    alloc_pred_i  = pred;
    ret_valid_i   = rv;
    ret_brdir_i   = dir;
    flush_i       = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] e_idx;
    logic [31:0] e_mp;
`ifdef BPUQ_STATS_EN
    logic [9:0]  pred_pat;
`endif
    idle();
    #12;
    // Reset state while reset is held.
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_ready", 32'(alloc_ready_o), 32'd1);
    check("rst_we", 32'(pht_brdir_we_o), 32'd0);
    check("rst_mp", 32'(mispredict_o), 32'd0);
    check("rst_uf", 32'(underflow_o), 32'd0);
    check("rst_idx", 32'(pht_wt_index_o), 32'd0);
    check("rst_dir", 32'(pht_brdir_o), 32'd0);
    reset_n = 1'b1;
    step();

    // Single allocate then mispredicted retire.
    drive(1'b1, 10'h155, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("t1_count1", 32'(count_o), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    check("t1_idx", 32'(pht_wt_index_o), 32'h155);
    check("t1_dir", 32'(pht_brdir_o), 32'd0);
    check("t1_we", 32'(pht_brdir_we_o), 32'd1);
    check("t1_mp", 32'(mispredict_o), 32'd1);
    check("t1_count0", 32'(count_o), 32'd0);
    step();
    check("t1_we_pulse", 32'(pht_brdir_we_o), 32'd0);
    check("t1_mp_pulse", 32'(mispredict_o), 32'd0);

    // Fill to full, ninth alloc ignored, drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 10'(i), 1'(i & 1), 1'b0, 1'b0, 1'b0);
      step();
    end
    check("t2_full_count", 32'(count_o), 32'd8);
    check("t2_full_ready", 32'(alloc_ready_o), 32'd0);
    drive(1'b1, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("t2_ninth_count", 32'(count_o), 32'd8);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b0, 1'b1, 1'(i & 1), 1'b0);
      step();
      check("t2_drain_idx", 32'(pht_wt_index_o), 32'(i));
      check("t2_drain_we", 32'(pht_brdir_we_o), 32'd1);
      check("t2_drain_mp", 32'(mispredict_o), 32'd0);
    end
    idle();
    check("t2_empty_count", 32'(count_o), 32'd0);
    check("t2_empty_ready", 32'(alloc_ready_o), 32'd1);
    check("t2_no_uf", 32'(underflow_o), 32'd0);

    // Full queue with simultaneous alloc+retire, then 20 cycles across the wrap.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 10'(32'h100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 10'h2AA, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("t3_full_ar_idx", 32'(pht_wt_index_o), 32'h100);
    check("t3_full_ar_we", 32'(pht_brdir_we_o), 32'd1);
    check("t3_full_ar_count", 32'(count_o), 32'd7);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 10'(32'h200 + k), 1'(k & 1), 1'b1, 1'b0, 1'b0);
      step();
      e_idx = (k < 7) ? 32'(32'h101 + k) : 32'(32'h200 + k - 7);
      e_mp  = (k < 7) ? 32'd0 : 32'((k - 7) & 1);
      check("t3_wrap_idx", 32'(pht_wt_index_o), e_idx);
      check("t3_wrap_mp", 32'(mispredict_o), e_mp);
      check("t3_wrap_count", 32'(count_o), 32'd7);
    end
    // Drain two: 0x20D (pred 1) and 0x20E (pred 0), retired not-taken.
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("t3_d0_idx", 32'(pht_wt_index_o), 32'h20D);
    check("t3_d0_mp", 32'(mispredict_o), 32'd1);
    step();
    check("t3_d1_idx", 32'(pht_wt_index_o), 32'h20E);
    check("t3_d1_mp", 32'(mispredict_o), 32'd0);
    check("t3_count5", 32'(count_o), 32'd5);

    // Flush together with retire and alloc; head is 0x20F with pred 1.
    drive(1'b1, 10'h111, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    idle();
    check("t4_idx", 32'(pht_wt_index_o), 32'h20F);
    check("t4_we", 32'(pht_brdir_we_o), 32'd1);
    check("t4_dir", 32'(pht_brdir_o), 32'd1);
    check("t4_mp", 32'(mispredict_o), 32'd0);
    check("t4_count", 32'(count_o), 32'd0);
    step();
    check("t4_we_off", 32'(pht_brdir_we_o), 32'd0);
    check("t4_count_hold", 32'(count_o), 32'd0);

    // Retire on empty queue: no update, sticky underflow.
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    check("t5_we", 32'(pht_brdir_we_o), 32'd0);
    check("t5_uf", 32'(underflow_o), 32'd1);
    check("t5_count", 32'(count_o), 32'd0);
    for (int i = 0; i < 3; i++) step();
    check("t5_uf_sticky", 32'(underflow_o), 32'd1);

    // Alloc into empty with simultaneous retire: stored, retire is underflow.
    drive(1'b1, 10'h0AB, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    check("t6_count", 32'(count_o), 32'd1);
    check("t6_we", 32'(pht_brdir_we_o), 32'd0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    check("t6_idx", 32'(pht_wt_index_o), 32'h0AB);
    check("t6_we2", 32'(pht_brdir_we_o), 32'd1);
    check("t6_mp", 32'(mispredict_o), 32'd0);

    // Asynchronous reset while an update pulse is live.
    drive(1'b1, 10'h3C3, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    idle();
    check("t7_we_live", 32'(pht_brdir_we_o), 32'd1);
    check("t7_mp_live", 32'(mispredict_o), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t7_we_rst", 32'(pht_brdir_we_o), 32'd0);
    check("t7_mp_rst", 32'(mispredict_o), 32'd0);
    check("t7_idx_rst", 32'(pht_wt_index_o), 32'd0);
    check("t7_count_rst", 32'(count_o), 32'd0);
    check("t7_ready_rst", 32'(alloc_ready_o), 32'd1);
    check("t7_uf_rst", 32'(underflow_o), 32'd0);
    #2;
    reset_n = 1'b1;
    step();

`ifdef BPUQ_STATS_EN
    // Ten retires, mispredicts on entries 0, 3 and 7, then a flush.
    pred_pat = 10'b0010001001;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) begin
        drive(1'b1, 10'(r * 5 + i), pred_pat[r * 5 + i], 1'b0, 1'b0, 1'b0);
        step();
      end
      for (int i = 0; i < 5; i++) begin
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    step();
    check("t8_retired", stat_retired_o, 32'd10);
    check("t8_mispred", stat_mispred_o, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
